// File: rtl/vend_pkg.sv
// Shared constants for the vending front end: input indices, coin vector
// layout, coin priority and the default debounce length.
package vend_pkg;

  localparam int NI       = 0;
  localparam int DI       = 1;
  localparam int QU       = 2;
  localparam int SODA     = 3;
  localparam int DIET     = 4;
  localparam int N_INPUTS = 5;

  // Bit positions inside the 3-bit coin vector {qu, di, ni}
  localparam int C_NI = 0;
  localparam int C_DI = 1;
  localparam int C_QU = 2;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

  // One-hot grant of the highest-priority request: qu > di > ni
  function automatic logic [2:0] coin_grant(input logic [2:0] req);
    logic [2:0] g;
    g = 3'b000;
    if (req[C_QU])      g[C_QU] = 1'b1;
    else if (req[C_DI]) g[C_DI] = 1'b1;
    else if (req[C_NI]) g[C_NI] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One conditioned input: 2-flop synchronizer, stability counter, debounced
// level and a 0->1 rise strobe on that level.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q, sync_d;
  logic [7:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    prev_d  = level_q;
    // Any sample agreeing with the level restarts the count from zero
    if (sync_q[1] == level_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = level_q & ~prev_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Conditions five raw vending inputs into registered single-cycle pulses with
// qu > di > ni coin arbitration. Define COIN_QUEUE_EN to queue losing coins.
module coin_input_conditioner
  import vend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic rst,
  input  logic ni_raw,
  input  logic di_raw,
  input  logic qu_raw,
  input  logic soda_raw,
  input  logic diet_raw,
  output logic ni,
  output logic di,
  output logic qu,
  output logic soda,
  output logic diet,
  output logic coin_drop
);

  logic [N_INPUTS-1:0] raw_vec;
  logic [N_INPUTS-1:0] rise_vec;
  logic [2:0]          coin_ev;
  logic [2:0]          coin_q, coin_d;
  logic                soda_q, soda_d;
  logic                diet_q, diet_d;
  logic                drop_q, drop_d;

  assign raw_vec[NI]   = ni_raw;
  assign raw_vec[DI]   = di_raw;
  assign raw_vec[QU]   = qu_raw;
  assign raw_vec[SODA] = soda_raw;
  assign raw_vec[DIET] = diet_raw;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_cell
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .CLK  (CLK),
      .rst  (rst),
      .raw  (raw_vec[g]),
      .rise (rise_vec[g])
    );
  end

  assign coin_ev[C_NI] = rise_vec[NI];
  assign coin_ev[C_DI] = rise_vec[DI];
  assign coin_ev[C_QU] = rise_vec[QU];

`ifdef COIN_QUEUE_EN
  logic [2:0] pend_q, pend_d;
  logic [2:0] coin_req;

  // Pending and fresh events compete together; a fresh event that lands on
  // a still-pending type cannot be stored twice, so it is reported as dropped.
  always_comb begin
    coin_req = pend_q | coin_ev;
    coin_d   = coin_grant(coin_req);
    pend_d   = coin_req & ~coin_d;
    drop_d   = |(coin_ev & pend_q & ~coin_d);
  end

  always_ff @(posedge CLK) begin
    if (rst) pend_q <= 3'b000;
    else     pend_q <= pend_d;
  end
`else
  always_comb begin
    coin_d = coin_grant(coin_ev);
    drop_d = |(coin_ev & ~coin_d);
  end
`endif

  // Selections never arbitrate against coins; a simultaneous diet just loses.
  always_comb begin
    soda_d = rise_vec[SODA];
    diet_d = rise_vec[DIET] & ~rise_vec[SODA];
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      coin_q <= 3'b000;
      soda_q <= 1'b0;
      diet_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      coin_q <= coin_d;
      soda_q <= soda_d;
      diet_q <= diet_d;
      drop_q <= drop_d;
    end
  end

  assign ni        = coin_q[C_NI];
  assign di        = coin_q[C_DI];
  assign qu        = coin_q[C_QU];
  assign soda      = soda_q;
  assign diet      = diet_q;
  assign coin_drop = drop_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEBOUNCE_CYCLES=4; expected
// pulse timing is D+3 edges after the first edge that samples a raw input high.
module tb_coin_input_conditioner;

  logic CLK;
  logic rst;
  logic ni_raw, di_raw, qu_raw, soda_raw, diet_raw;
  logic ni, di, qu, soda, diet, coin_drop;

  int tests_run;
  int tests_failed;
  int edge_n;
  int mutex_viol;
  // Per output {ni, di, qu, soda, diet, coin_drop}: high-cycle count, first high edge
  int n_hi[6];
  int e_hi[6];

  localparam int O_NI = 0, O_DI = 1, O_QU = 2, O_SODA = 3, O_DIET = 4, O_DROP = 5;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .ni_raw    (ni_raw),
    .di_raw    (di_raw),
    .qu_raw    (qu_raw),
    .soda_raw  (soda_raw),
    .diet_raw  (diet_raw),
    .ni        (ni),
    .di        (di),
    .qu        (qu),
    .soda      (soda),
    .diet      (diet),
    .coin_drop (coin_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_counts();
    edge_n = 0;
    for (int i = 0; i < 6; i++) begin
      n_hi[i] = 0;
      e_hi[i] = 0;
    end
  endtask

  // One rising edge, then sample outputs 1 time unit later
  task automatic tick();
    logic [5:0] o;
    @(posedge CLK);
    #1;
    edge_n++;
    o = {coin_drop, diet, soda, qu, di, ni};
    for (int i = 0; i < 6; i++) begin
      if (o[i]) begin
        n_hi[i]++;
        if (e_hi[i] == 0) e_hi[i] = edge_n;
      end
    end
    if (int'(ni) + int'(di) + int'(qu) > 1) mutex_viol++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_all();
    ni_raw = 0; di_raw = 0; qu_raw = 0; soda_raw = 0; diet_raw = 0;
    ticks(12);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mutex_viol   = 0;
    ni_raw = 0; di_raw = 0; qu_raw = 0; soda_raw = 0; diet_raw = 0;
    rst = 1;
    clear_counts();

    // Reset: outputs forced low even with raw inputs high
    qu_raw = 1; ni_raw = 1;
    ticks(8);
    chk("reset_outputs", int'({coin_drop, diet, soda, qu, di, ni}), 0);
    chk("reset_no_pulse", n_hi[O_QU] + n_hi[O_NI] + n_hi[O_DROP], 0);
    qu_raw = 0; ni_raw = 0;
    ticks(2);
    rst = 0;
    ticks(3);

    // qu held high: exactly the cycle after edge 7
    clear_counts();
    qu_raw = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("qu_timing_e%0d", k), int'(qu), (k == 7) ? 1 : 0);
    end
    chk("qu_only_count", n_hi[O_QU], 1);
    chk("qu_others_quiet", n_hi[O_NI] + n_hi[O_DI] + n_hi[O_SODA] + n_hi[O_DIET] + n_hi[O_DROP], 0);
    release_all();
    chk("qu_release_no_pulse", n_hi[O_QU], 1);

    // di bouncing every 2 cycles: no pulse; then stable high: one pulse
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      di_raw = ((i / 2) % 2 == 0);
      tick();
    end
    di_raw = 0;
    ticks(8);
    chk("di_bounce_no_pulse", n_hi[O_DI], 0);
    clear_counts();
    di_raw = 1;
    ticks(10);
    chk("di_stable_count", n_hi[O_DI], 1);
    chk("di_stable_edge", e_hi[O_DI], 7);
    release_all();

    // Glitch boundary: 3 raw samples never qualify, 4 samples just do
    clear_counts();
    qu_raw = 1;
    ticks(3);
    qu_raw = 0;
    ticks(12);
    chk("glitch3_no_pulse", n_hi[O_QU], 0);
    clear_counts();
    qu_raw = 1;
    ticks(4);
    qu_raw = 0;
    ticks(12);
    chk("glitch4_pulse", n_hi[O_QU], 1);
    chk("glitch4_edge", e_hi[O_QU], 7);

    // Three coins rising together
    clear_counts();
    qu_raw = 1; di_raw = 1; ni_raw = 1;
    ticks(12);
    chk("tri_qu_edge", e_hi[O_QU], 7);
    chk("tri_qu_count", n_hi[O_QU], 1);
`ifdef COIN_QUEUE_EN
    chk("tri_di_edge", e_hi[O_DI], 8);
    chk("tri_ni_edge", e_hi[O_NI], 9);
    chk("tri_di_count", n_hi[O_DI], 1);
    chk("tri_ni_count", n_hi[O_NI], 1);
    chk("tri_drop_count", n_hi[O_DROP], 0);
`else
    chk("tri_di_count", n_hi[O_DI], 0);
    chk("tri_ni_count", n_hi[O_NI], 0);
    chk("tri_drop_edge", e_hi[O_DROP], 7);
    chk("tri_drop_count", n_hi[O_DROP], 1);
`endif
    release_all();

    // soda and diet together: soda only
    clear_counts();
    soda_raw = 1; diet_raw = 1;
    ticks(12);
    chk("sel_soda_count", n_hi[O_SODA], 1);
    chk("sel_soda_edge", e_hi[O_SODA], 7);
    chk("sel_diet_count", n_hi[O_DIET], 0);
    chk("sel_drop_count", n_hi[O_DROP], 0);
    release_all();

    // ni held high, rst pulsed at edge 5: pulse 7 edges after rst drops
    clear_counts();
    ni_raw = 1;
    ticks(4);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_no_pulse", n_hi[O_NI], 0);
    ticks(10);
    chk("rst_mid_ni_count", n_hi[O_NI], 1);
    chk("rst_mid_ni_edge", e_hi[O_NI], 12);
    release_all();

    // Long hold is one event; release and re-press gives a second
    clear_counts();
    qu_raw = 1;
    ticks(50);
    chk("hold50_count", n_hi[O_QU], 1);
    qu_raw = 0;
    ticks(10);
    chk("hold50_release", n_hi[O_QU], 1);
    qu_raw = 1;
    ticks(12);
    chk("repress_count", n_hi[O_QU], 2);
    release_all();

    chk("coin_mutex", mutex_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
